// File: rtl/buzzer_pkg.sv
// Shared note table, source/state encodings and effect sequence lookup for the buzzer arbiter.
package buzzer_pkg;

    localparam int NOTE_W = 17;
    typedef logic [NOTE_W-1:0] note_t;

    // Half-periods in 100 MHz clk cycles; 0 is a rest.
    localparam note_t REST = 17'd0;
    localparam note_t L_1  = 17'd127552;
    localparam note_t L_2  = 17'd113636;
    localparam note_t L_3  = 17'd101239;
    localparam note_t L_4  = 17'd95556;
    localparam note_t L_5  = 17'd85136;
    localparam note_t L_6  = 17'd75843;
    localparam note_t L_7  = 17'd67568;
    localparam note_t M_1  = 17'd63776;
    localparam note_t M_2  = 17'd56818;
    localparam note_t M_3  = 17'd50607;
    localparam note_t M_4  = 17'd47778;
    localparam note_t M_5  = 17'd42553;
    localparam note_t M_6  = 17'd37922;
    localparam note_t M_7  = 17'd33784;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_HIT   = 2'd1,
        SRC_SCORE = 2'd2,
        SRC_OVER  = 2'd3
    } src_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        NEXT = 2'd2
    } state_t;

    localparam int IDX_W = 3;
    typedef logic [IDX_W-1:0] idx_t;

    function automatic idx_t seq_last(input src_t s);
        case (s)
            SRC_HIT:   return 3'd1;
            SRC_SCORE: return 3'd3;
            SRC_OVER:  return 3'd7;
            default:   return 3'd0;
        endcase
    endfunction

    function automatic note_t seq_note(input src_t s, input idx_t i);
        note_t n;
        n = REST;
        case (s)
            SRC_HIT: n = M_5;
            SRC_SCORE: begin
                case (i)
                    3'd0:    n = M_1;
                    3'd1:    n = M_3;
                    default: n = M_5;
                endcase
            end
            SRC_OVER: begin
                case (i)
                    3'd0:    n = M_5;
                    3'd1:    n = M_3;
                    3'd2:    n = M_1;
                    3'd3:    n = L_5;
                    3'd4:    n = L_5;
                    3'd5:    n = REST;
                    3'd6:    n = L_5;
                    default: n = L_5;
                endcase
            end
            default: n = REST;
        endcase
        return n;
    endfunction

    // Pending bits: [0] hit, [1] score, [2] over; the highest set bit wins.
    function automatic src_t top_pending(input logic [2:0] p);
        if (p[2])      return SRC_OVER;
        else if (p[1]) return SRC_SCORE;
        else if (p[0]) return SRC_HIT;
        else           return SRC_NONE;
    endfunction

    function automatic logic [2:0] src_mask(input src_t s);
        case (s)
            SRC_HIT:   return 3'b001;
            SRC_SCORE: return 3'b010;
            SRC_OVER:  return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/buzzer_arbiter_tone_gen.sv
// Half-period tone generator: toggles its output every `half` cycles, silent for a rest.
module tone_gen #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] half,
    output logic         tone
);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_inc;

    assign cnt_inc = cnt + 1'b1;

    // clr marks the first cycle of a new note so every note starts from a clean phase.
    always_ff @(posedge clk) begin
        if (rst || !en || clr || (half == '0)) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (cnt_inc == half) begin
            cnt  <= '0;
            tone <= ~tone;
        end else begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/buzzer_arbiter.sv
// Priority arbiter for game sound effects over background music on a single buzzer.
// Define BUZZER_MUSIC_PASS_EN to add the music_in/music_en pass-through while idle.
module buzzer_arbiter
    import buzzer_pkg::*;
#(
    parameter int STEP_CYC = 15555555,
    parameter int MAX_HALF = 131071
) (
    input  logic       clk,
    input  logic       rst,
`ifdef BUZZER_MUSIC_PASS_EN
    input  logic       music_in,
    input  logic       music_en,
`endif
    input  logic       hit_req,
    input  logic       score_req,
    input  logic       over_req,
    output logic       beep,
    output logic       sd,
    output logic       busy,
    output logic [1:0] active_src
);

    localparam int STEP_W = (STEP_CYC > 2) ? $clog2(STEP_CYC) : 1;
    // PLAY hands over to NEXT one cycle early so that NEXT is the last cycle of the step.
    localparam logic [STEP_W-1:0] PLAY_END = STEP_W'(STEP_CYC - 2);
    localparam int HALF_CAP = (MAX_HALF > 131071) ? 131071 : MAX_HALF;
    localparam note_t HALF_MAX = NOTE_W'(HALF_CAP);

    logic [2:0]        req_now;
    logic [2:0]        req_d;
    logic [2:0]        req_rise;
    logic [2:0]        pend;
    logic [2:0]        take;
    state_t            state;
    src_t              src;
    src_t              want;
    idx_t              idx;
    logic [STEP_W-1:0] step_cnt;
    logic              note_start;
    logic              start;
    logic              preempt;
    logic              last_note;
    note_t             raw_note;
    note_t             note;
    logic              tone;
    logic              music_bit;

    assign req_now   = {over_req, score_req, hit_req};
    assign req_rise  = req_now & ~req_d;
    assign want      = top_pending(pend);
    assign preempt   = (want != SRC_NONE) && (want >= src);
    assign last_note = (idx == seq_last(src));

    always_comb begin
        start = 1'b0;
        case (state)
            IDLE:    start = (want != SRC_NONE);
            PLAY:    start = preempt;
            NEXT:    start = preempt || (last_note && (want != SRC_NONE));
            default: start = 1'b0;
        endcase
    end

    assign take = start ? src_mask(want) : 3'b000;

    always_ff @(posedge clk) begin
        if (rst) begin
            // req_d follows the pins during reset so a level held through reset is not an edge.
            req_d      <= req_now;
            pend       <= 3'b000;
            state      <= IDLE;
            src        <= SRC_NONE;
            idx        <= '0;
            step_cnt   <= '0;
            busy       <= 1'b0;
            note_start <= 1'b0;
        end else begin
            req_d      <= req_now;
            pend       <= (pend & ~take) | req_rise;
            note_start <= 1'b0;
            if (start) begin
                state      <= PLAY;
                src        <= want;
                idx        <= '0;
                step_cnt   <= '0;
                busy       <= 1'b1;
                note_start <= 1'b1;
            end else begin
                case (state)
                    PLAY: begin
                        step_cnt <= step_cnt + 1'b1;
                        if (step_cnt == PLAY_END) begin
                            state <= NEXT;
                        end
                    end
                    NEXT: begin
                        step_cnt <= '0;
                        if (!last_note) begin
                            idx        <= idx + 1'b1;
                            state      <= PLAY;
                            note_start <= 1'b1;
                        end else begin
                            state <= IDLE;
                            src   <= SRC_NONE;
                            idx   <= '0;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        step_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign raw_note = seq_note(src, idx);
    assign note     = (raw_note > HALF_MAX) ? HALF_MAX : raw_note;

    tone_gen #(
        .W(NOTE_W)
    ) u_tone_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .clr  (note_start),
        .half (note),
        .tone (tone)
    );

`ifdef BUZZER_MUSIC_PASS_EN
    assign music_bit = music_en & music_in;
`else
    assign music_bit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            beep <= 1'b0;
        end else if (busy) begin
            beep <= tone;
        end else begin
            beep <= music_bit;
        end
    end

    assign active_src = src;
    assign sd         = 1'b1;

endmodule

// File: doc/buzzer_arbiter.md
BUZZER_ARBITER -- requirements
Module: buzzer_arbiter

Interface
REQ-001 SHALL have parameter STEP_CYC, default 15555555, giving one note step in clk cycles (156 ms at 100 MHz).
REQ-002 SHALL have parameter MAX_HALF, default 131071, the largest legal note half-period; wider table values are clipped to it.
REQ-003 SHALL have port clk, input, 1 bit: 100 MHz system clock, the only clock.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port music_in, input, 1 bit: square wave from the background music player.
REQ-006 SHALL have port music_en, input, 1 bit: background music allowed when high.
REQ-007 SHALL have port hit_req, input, 1 bit: paddle-hit effect request, level sampled per cycle, rising edge counts.
REQ-008 SHALL have port score_req, input, 1 bit: point-scored effect request, rising edge counts.
REQ-009 SHALL have port over_req, input, 1 bit: game-over effect request, rising edge counts.
REQ-010 SHALL have port beep, output, 1 bit: buzzer drive, registered.
REQ-011 SHALL have port sd, output, 1 bit: amplifier shutdown-n, constant 1.
REQ-012 SHALL have port busy, output, 1 bit: high while an effect plays.
REQ-013 SHALL have port active_src, output, 2 bits: 0 = none/music, 1 = hit, 2 = score, 3 = over.

Function
REQ-014 SHALL use priority over > score > hit > music.
REQ-015 SHALL play these effect sequences, each entry lasting 1 step: hit = M_5, M_5; score = M_1, M_3, M_5, M_5; over = M_5, M_3, M_1, L_5, L_5, rest, L_5, L_5.
REQ-016 SHALL use a state machine with states IDLE, PLAY and NEXT: IDLE->PLAY on any pending request; PLAY->NEXT when the step counter reaches STEP_CYC-1; NEXT->PLAY if notes remain, else ->IDLE or ->PLAY for the highest pending request.
REQ-017 SHALL register each request edge into a per-source pending bit in cycle t+1; busy and active_src SHALL be valid in cycle t+2.
REQ-018 SHALL let a request of higher priority than active_src preempt the current effect: the higher effect restarts at note 0 and the preempted effect is discarded, not resumed.
REQ-019 SHALL make an equal-priority request restart the active effect at note 0.
REQ-020 SHALL hold a lower-priority request pending and start it in the NEXT cycle that ends the current effect.
REQ-021 SHALL treat simultaneous request edges as follows: the highest source plays and the others stay pending.
REQ-022 SHALL generate tones with a half-period counter that toggles beep when the count equals the note value, then clears to 0; the counter SHALL reset to 0 at every note change.
REQ-023 SHALL hold beep low and the counter at 0 for a rest (note value 0).
REQ-024 SHALL make beep follow music_in with one cycle of delay when IDLE and music_en=1, and be 0 when IDLE and music_en=0.

Reset
REQ-025 SHALL, on rst=1 at a clk edge, set state IDLE, clear all pending bits, step counter and tone counter, and drive beep=0, busy=0, active_src=0; sd stays 1.
REQ-026 SHALL abandon any effect in progress when reset is asserted mid-effect, and SHALL NOT replay it after reset.
REQ-027 SHALL ignore request levels high during reset until they go low and rise again.

Configuration
REQ-028 SHALL compile in background music pass-through when BUZZER_MUSIC_PASS_EN is defined (REQ-024 applies).
REQ-029 SHALL, when BUZZER_MUSIC_PASS_EN is undefined, omit the music_in and music_en ports and hold beep at 0 when IDLE.

Structure
REQ-030 SHALL place the note half-period constants L_1..M_7 in shared package buzzer_pkg, with L_1=127552, L_5=85136, M_1=63776, M_3=50607, M_5=42553.
REQ-031 SHALL place the source encoding and the effect sequence lookup in buzzer_pkg.
REQ-032 SHALL implement the half-period counter and toggle as one sub-module, tone_gen.

Verification
REQ-033 SHALL verify, with STEP_CYC=200000: hit_req pulse at t -> active_src=1 and busy=1 at t+2, beep period 85106 cycles, busy low after 400000 cycles.
REQ-034 SHALL verify: during hit playback, over_req pulse -> active_src=3 within 2 cycles, first note half-period 42553, and hit not resumed afterwards.
REQ-035 SHALL verify: over playing, then score_req pulse -> score starts in the cycle after over's last step; total busy time 12 steps.
REQ-036 SHALL verify: hit_req, score_req and over_req rising in the same cycle -> order over, score, hit; busy continuous for 14 steps.
REQ-037 SHALL verify: rst asserted at step 3 of over with over_req held high -> all outputs at reset values next cycle, no replay until over_req toggles.
REQ-038 SHALL verify: IDLE, music_en=1, 1 kHz music_in -> beep equals music_in delayed by 1 cycle; music_en=0 -> beep=0.
